// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- multi-cycle 32-bit integer divider (EX-stage divide responder)
//
// Restoring division, one quotient bit per clock, MSB first. Signed requests
// are divided on magnitudes and the signs are applied when the result is
// registered. The result is held, with ready_o, until EX drops start_i.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       cancel any in-flight divide (pipeline flush)
//   result_o      {remainder[63:32], quotient[31:0]}  (HI, LO)
//   ready_o       result valid
// -----------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_cnt;
  logic [31:0] r_dvd;     // dividend magnitude, shifted out MSB first
  logic [31:0] r_dvs;     // divisor magnitude
  logic [31:0] r_rem;     // partial remainder (always < divisor)
  logic [31:0] r_quo;     // quotient bits shifted in LSB side
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic        w_abort;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

  assign w_accept = start_i && !annul_i;
  // Losing start or seeing annul both mean EX no longer wants this result.
  assign w_abort  = annul_i || !start_i;

  assign w_abs1 = cond_neg(signed_div_i && opdata1_i[31], opdata1_i);
  assign w_abs2 = cond_neg(signed_div_i && opdata2_i[31], opdata2_i);

  // Trial subtraction is done on 33 bits; when it succeeds the difference is
  // smaller than the divisor, so the low 32 bits are the whole remainder.
  assign w_trial = {r_rem, r_dvd[31]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial[31:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) begin
          w_state_nxt = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: w_state_nxt = S_END;
      S_ON: begin
        if (w_abort) begin
          w_state_nxt = S_FREE;
        end else if (r_cnt == 6'd32) begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        if (w_abort) begin
          w_state_nxt = S_FREE;
        end
      end
      default: w_state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        // operand capture
        S_FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (w_accept) begin
            r_cnt   <= '0;
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rem   <= '0;
            r_quo   <= '0;
            r_neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            r_neg_r <= signed_div_i && opdata1_i[31];
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
        end
        // iteration, then sign fix into the result register
        S_ON: begin
          if (w_abort) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end else if (r_cnt != 6'd32) begin
            r_rem <= w_ge ? w_diff : w_trial[31:0];
            r_quo <= {r_quo[30:0], w_ge};
            r_dvd <= {r_dvd[30:0], 1'b0};
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_result <= {cond_neg(r_neg_r, r_rem), cond_neg(r_neg_q, r_quo)};
            r_ready  <= 1'b1;
          end
        end
        // result hold
        S_END: begin
          if (w_abort) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          hold;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic on the mathematical values, truncated.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Called right after the accepting edge E0 has been passed (at #1).
  // Scrambles operands, waits for ready, checks latency, result, hold, drop.
  task automatic finish_op(input logic [63:0] exp, input int exp_lat, input int hold, input string nm);
    int   lat;
    logic got;
    lat = 0;
    got = 1'b0;
    signed_div_i = $urandom_range(0, 1);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ready_o) got = 1'b1;
    end
    chk({nm, " latency"}, 64'(got ? lat : -1), 64'(exp_lat));
    chk({nm, " result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold"}, {result_o[63:1], result_o[0] ^ ~ready_o}, {exp[63:1], exp[0]});
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({nm, " drop ready"}, {63'd0, ready_o}, 64'd0);
    chk({nm, " drop result"}, result_o, 64'd0);
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int hold, input string nm);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    finish_op(exp, (b == 32'd0) ? 1 : 33, hold, nm);
  endtask

  vec_t tbl[$];

  initial begin
    logic        s;
    logic [31:0] a, b;

    tbl.push_back('{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 5, "u100/7"});
    tbl.push_back('{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 0, "s-7/2"});
    tbl.push_back('{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0, "s7/-2"});
    tbl.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 0, "smin/-1"});
    tbl.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 0, "umin/max"});
    tbl.push_back('{1'b0, 32'h12345678,   32'd0,        64'h0,                 2, "u/0"});
    tbl.push_back('{1'b1, 32'hFFFFFFFF,   32'd0,        64'h0,                 0, "s/0"});
    tbl.push_back('{1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF, 0, "uff/10"});
    tbl.push_back('{1'b1, 32'd0,          32'hFFFFFFF3, 64'h0,                 0, "s0/-13"});
    tbl.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 0, "s-100/-7"});

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle ready", {63'd0, ready_o}, 64'd0);

    // Table vectors, run back to back (start low for exactly one edge between).
    foreach (tbl[i]) do_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold, tbl[i].nm);

    // Annul at step 10, then a new request on the following edge.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    begin
      int early;
      early = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (ready_o) early++;
      end
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk); #1;
      if (ready_o) early++;
      chk("annul no ready", 64'(early), 64'd0);
      chk("annul result", result_o, 64'd0);
      annul_i = 1'b0;
      opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'h10;
      @(posedge clk); #1;
      finish_op(64'h0000000F_0FFFFFFF, 33, 0, "after annul");
    end

    // Reset at step 20 with start held, then fresh op from FREE.
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFC18; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst mid ready", {63'd0, ready_o}, 64'd0);
    chk("rst mid result", result_o, 64'd0);
    rst = 1'b0;
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFC18; opdata2_i = 32'd7;
    @(posedge clk); #1;
    finish_op(ref_div(1'b1, 32'hFFFFFC18, 32'd7), 33, 1, "after rst");

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: a = $urandom_range(0, 100);
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: b = {{16{b[15]}}, b[15:0]};
        default: ;
      endcase
      do_op(s, a, b, ref_div(s, a, b), 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider; the responder side of the EX-stage divide handshake.
- EX drives operands, signedness and start. This block iterates one quotient bit per cycle, then returns {remainder, quotient} with ready held until EX drops start.
- Result feeds the HI/LO write path: HI = remainder, LO = quotient.

Parameters:
- none; datapath fixed at 32-bit operands, 64-bit result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request; held high by EX until ready_o seen
- annul_i  input  1  cancel in-flight divide (pipeline flush)
- result_o  output  64  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result valid

Behaviour:
- Reset: clk edge with rst=1 → state FREE, cnt=0, result_o=0, ready_o=0, internal registers cleared. Reset overrides all other inputs. Reset mid-operation discards the operation.
- States: FREE, BYZERO, ON, END. cnt is 6 bits.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i=0 → BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 → ON, cnt=0.
  - Operands latched at this edge (E0). In signed mode, the absolute value of each negative operand is latched, plus the dividend sign and the quotient sign (s1 XOR s2).
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next edge → END, result 0x0000000000000000, ready_o=1.
- ON (restoring division, MSB first, one bit per edge):
  - Partial remainder r is 33 bits. Each edge: r = {r[31:0], next dividend bit}; if r ≥ divisor then r -= divisor and the quotient bit is 1, else 0. cnt increments.
  - After 32 steps (edges E1..E32), edge E33 → END.
  - Result registered with sign fix: quotient negated if the quotient sign is set; remainder negated if the dividend was negative (remainder takes the dividend's sign).
  - ready_o=1 visible after E33.
  - annul_i=1 or start_i=0 on any ON edge → FREE, ready_o=0, result_o=0; no partial result is ever exposed.
- END:
  - start_i=1 → hold; result_o and ready_o stable.
  - start_i=0 → FREE; ready_o=0 and result_o=0 after that edge.
  - annul_i in END is treated the same as start_i=0.
- Operand changes after E0 are ignored until the next acceptance.
- A new request can be accepted on the edge after returning to FREE (no extra idle cycle).
- Arithmetic rules:
  - Unsigned mode does no sign processing.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (wraps; no trap).
  - Dividend 0 with nonzero divisor → 0/0 result via the normal ON path, full latency.
- Latency: nonzero divisor → ready 33 edges after E0; zero divisor → 1 edge after E0.

Test Plan:
- Unsigned 100/7, start held → ready_o rises exactly 33 edges after acceptance, result_o=0x00000002_0000000E; drop start → ready_o=0 and result_o=0 next edge.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/−2 → 0x00000001_FFFFFFFD. Signed 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
- Divisor 0 in either mode → ready_o high 1 edge after acceptance, result_o=0.
- annul_i pulsed at step 10 → FREE, ready_o never asserts. A new request (unsigned 0xFFFFFFFF/0x10) on the following edge completes normally with 0x0000000F_0FFFFFFF.
- rst asserted at step 20, then released with start held → no ready from the aborted op; a fresh op starts from FREE and finishes 33 edges after re-acceptance. Operands changed mid-ON are ignored.
- Start held 5 extra cycles in END → result_o and ready_o stable throughout. Back-to-back ops (drop start 1 cycle, reassert) → both results correct.
